// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// The response state doubles as the owner of the in-flight RAM access.
// Imported by the arbiter RTL and by any monitor that decodes owners.
package mem_arb_pkg;

    // Owner of the access issued in the previous cycle.
    // IDLE: nothing in flight.
    // INST_RSP: fetch response due.
    // DATA_RSP: load or store response due.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INST_RSP = 2'd1,
        DATA_RSP = 2'd2
    } rsp_state_e;

    // Next response owner from this cycle's grants.
    // The grants are mutually exclusive.
    function automatic rsp_state_e next_rsp_state(input logic ignt, input logic dgnt);
        rsp_state_e s;
        s = IDLE;
        if (dgnt) begin
            s = DATA_RSP;
        end else if (ignt) begin
            s = INST_RSP;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant logic: data port wins unless the fetch has been starved STARVE_LIMIT times.
// Latency: combinational grants, with the streak counter registered.
// Backpressure: the loser simply gets no grant; the top turns that into a stall.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset; grants are forced low during reset.
//   ireq, dreq  fetch and data requests.
//   ignt, dgnt  one-hot-or-zero grants.
module mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ireq,
    input  logic dreq,
    output logic ignt,
    output logic dgnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          starved;

    always_comb begin
        starved  = ireq && (streak_q == LIMIT);
        dgnt     = rst_n & dreq & ~starved;
        ignt     = rst_n & ireq & ~dgnt;
        streak_d = streak_q;
        // The streak counts only data wins taken while a fetch waits.
        // A fetch win, or no fetch pending, restarts the count.
        if (ignt || !ireq) begin
            streak_d = '0;
        end else if (dgnt && (streak_q != LIMIT)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between the core's fetch and load/store ports.
// Latency: issue in the request cycle; response flag and data one cycle after the grant.
// Backpressure: stall_o is high while any pending request is not granted; the core holds its request.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset.
//   inst_ce_i, inst_addr_i     fetch request.
//   inst_o, inst_valid_o       fetched word (held) and its update strobe.
//   data_ce_i, data_we_i       load and store requests.
//   data_addr_i, data_wdata_i  address and store data.
//   data_rdata_o, data_ready_o load data (held) and completion strobe.
//   stall_o                    a pending request lost arbitration this cycle.
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  RAM port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_ce_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    input  logic                  data_ce_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_ready_o,
    output logic                  stall_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    logic ireq;
    logic dreq;
    logic ignt;
    logic dgnt;

    assign ireq = inst_ce_i;
    assign dreq = data_ce_i | data_we_i;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .ireq  (ireq),
        .dreq  (dreq),
        .ignt  (ignt),
        .dgnt  (dgnt)
    );

    rsp_state_e            state_q;
    rsp_state_e            state_d;
    logic                  is_load_q;
    logic                  is_load_d;
    logic [DATA_WIDTH-1:0] inst_hold_q;
    logic [DATA_WIDTH-1:0] inst_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic [DATA_WIDTH-1:0] data_hold_d;

    always_comb begin
        state_d = next_rsp_state(ignt, dgnt);
        // A store wins over data_ce_i.
        // Remember the access kind so the response knows whether to load data.
        is_load_d = is_load_q;
        if (dgnt) begin
            is_load_d = ~data_we_i;
        end

        mem_en_o    = dgnt | ignt;
        mem_we_o    = dgnt & data_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (dgnt) begin
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (ignt) begin
            mem_addr_o = inst_addr_i;
        end

        // Gated by rst_n so the core sees no stall while the arbiter is held in reset.
        stall_o = rst_n & ((ireq & ~ignt) | (dreq & ~dgnt));

        inst_valid_o = (state_q == INST_RSP);
        data_ready_o = (state_q == DATA_RSP);
        inst_hold_d  = inst_hold_q;
        data_hold_d  = data_hold_q;
        inst_o       = inst_hold_q;
        data_rdata_o = data_hold_q;
        // In the response cycle the RAM word bypasses straight to the port.
        // The hold register catches the same word for the following cycles.
        if (state_q == INST_RSP) begin
            inst_o      = mem_rdata_i;
            inst_hold_d = mem_rdata_i;
        end
        if ((state_q == DATA_RSP) && is_load_q) begin
            data_rdata_o = mem_rdata_i;
            data_hold_d  = mem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            inst_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        dce;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        stall_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_ce_i    (ice),
        .inst_addr_i  (iaddr),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .data_ce_i    (dce),
        .data_we_i    (dwe),
        .data_addr_i  (daddr),
        .data_wdata_i (dwdata),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .stall_o      (stall_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Environment RAM seen by the DUT.
    // The port is sampled mid-cycle and acted on at the edge.
    // Non-read cycles drive noise on rdata so stale bypasses show up.
    logic [31:0] ram [1024];
    logic        s_en;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    always @(negedge clk) begin
        s_en    = mem_en_o;
        s_we    = mem_we_o;
        s_addr  = mem_addr_o;
        s_wdata = mem_wdata_o;
    end

    always @(posedge clk) begin
        if (s_en && s_we) begin
            ram[s_addr[11:2]] = s_wdata;
        end
        if (s_en && !s_we) begin
            mem_rdata_i <= ram[s_addr[11:2]];
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    // Reference model: expected memory contents, fetch-starvation count and
    // the response promised for the next cycle.
    logic [31:0] mdl [1024];
    int          m_streak;
    logic        exp_ivld;
    logic        exp_drdy;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
    logic        last_ig;
    logic        last_dg;
    int          n_chk;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        exp_ivld = 1'b0;
        exp_drdy = 1'b0;
        exp_inst = '0;
        exp_data = '0;
        last_ig  = 1'b0;
        last_dg  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_data_ready", 32'(data_ready_o), 32'd0);
        check("rst_inst_o",     inst_o,            32'd0);
        check("rst_data_rdata", data_rdata_o,      32'd0);
        check("rst_mem_en",     32'(mem_en_o),     32'd0);
        check("rst_mem_we",     32'(mem_we_o),     32'd0);
        check("rst_mem_addr",   mem_addr_o,        32'd0);
        check("rst_mem_wdata",  mem_wdata_o,       32'd0);
        check("rst_stall",      32'(stall_o),      32'd0);
    endtask

    // One clock cycle: check everything mid-cycle against the model, advance
    // the model, then return just after the next rising edge.
    task automatic step();
        logic ireq;
        logic dreq;
        logic ig;
        logic dg;
        logic [31:0] e_addr;
        @(negedge clk);
        ireq = ice;
        dreq = dce | dwe;
        // A waiting fetch wins only after SL straight data wins.
        dg = dreq && !(ireq && m_streak == SL);
        ig = ireq && !dg;
        e_addr = dg ? daddr : (ig ? iaddr : 32'd0);
        check("mem_en",     32'(mem_en_o),     32'(dg | ig));
        check("mem_we",     32'(mem_we_o),     32'(dg & dwe));
        check("mem_addr",   mem_addr_o,        e_addr);
        check("mem_wdata",  mem_wdata_o,       dg ? dwdata : 32'd0);
        check("stall",      32'(stall_o),      32'((ireq && !ig) || (dreq && !dg)));
        check("inst_valid", 32'(inst_valid_o), 32'(exp_ivld));
        check("inst_o",     inst_o,            exp_inst);
        check("data_ready", 32'(data_ready_o), 32'(exp_drdy));
        check("data_rdata", data_rdata_o,      exp_data);
        exp_ivld = ig;
        exp_drdy = dg;
        if (ig) begin
            exp_inst = mdl[iaddr[11:2]];
        end
        if (dg) begin
            if (dwe) begin
                mdl[daddr[11:2]] = dwdata;
            end else begin
                exp_data = mdl[daddr[11:2]];
            end
        end
        m_streak = (dg && ireq) ? m_streak + 1 : 0;
        last_ig  = ig;
        last_dg  = dg;
        @(posedge clk);
        #1;
    endtask

    // Core model.
    // A stalled request is held unchanged or withdrawn outright.
    // Otherwise a fresh request is drawn; pd is the data-request percentage.
    task automatic next_rand(input int pd);
        int r;
        if (ice && !last_ig) begin
            if ($urandom_range(7) == 0) ice = 1'b0;
        end else begin
            ice   = ($urandom_range(99) < 60);
            iaddr = 32'($urandom_range(63)) << 2;
        end
        if ((dce || dwe) && !last_dg) begin
            if ($urandom_range(7) == 0) begin
                dce = 1'b0;
                dwe = 1'b0;
            end
        end else begin
            r      = $urandom_range(99);
            dce    = 1'b0;
            dwe    = 1'b0;
            daddr  = 32'($urandom_range(63)) << 2;
            dwdata = $urandom;
            if (r < pd) begin
                r = $urandom_range(9);
                if (r < 6) begin
                    dce = 1'b1;
                end else begin
                    dwe = 1'b1;
                    dce = (r == 9);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        ice    = 1'b0;
        iaddr  = '0;
        dce    = 1'b0;
        dwe    = 1'b0;
        daddr  = '0;
        dwdata = '0;
    endtask

    initial begin
        int first_ig;
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        for (int i = 0; i < 3; i++) begin
            ram[i] = 32'h0000_0013;
            mdl[i] = 32'h0000_0013;
        end
        ram[32'h100 >> 2] = 32'hDEAD_BEEF;
        mdl[32'h100 >> 2] = 32'hDEAD_BEEF;
        model_reset();

        // In reset with both requests raised, nothing is granted and nothing stalls.
        rst_n = 1'b0;
        idle_inputs();
        ice   = 1'b1;
        dce   = 1'b1;
        daddr = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;

        // Back-to-back fetches from 0x00, 0x04 and 0x08.
        for (int k = 0; k < 3; k++) begin
            ice   = 1'b1;
            iaddr = 32'(k * 4);
            step();
        end
        idle_inputs();
        step();
        check("fetch_word", inst_o, 32'h0000_0013);

        // A fetch and a load in the same cycle: the load wins, then the fetch.
        ice   = 1'b1;
        iaddr = 32'h0C;
        dce   = 1'b1;
        daddr = 32'h100;
        step();
        dce = 1'b0;
        step();
        ice = 1'b0;
        step();
        check("load_deadbeef", data_rdata_o, 32'hDEAD_BEEF);

        // Continuous loads against a held fetch.
        // The fetch gets through on the fifth cycle.
        first_ig = 0;
        for (int k = 1; k <= 10; k++) begin
            ice   = 1'b1;
            iaddr = 32'h10;
            dce   = 1'b1;
            daddr = 32'(k * 4);
            step();
            if (last_ig && first_ig == 0) first_ig = k;
        end
        check("starve_grant_cycle", 32'(first_ig), 32'd5);
        idle_inputs();
        step();

        // A store to 0x200, then a load from 0x200.
        dwe    = 1'b1;
        daddr  = 32'h200;
        dwdata = 32'h1234_5678;
        step();
        dwe = 1'b0;
        dce = 1'b1;
        step();
        dce = 1'b0;
        step();
        check("store_then_load", data_rdata_o, 32'h1234_5678);

        // A fetch withdrawn while stalled behind a load.
        // No read happens at the fetch address and no fetch response follows.
        ice   = 1'b1;
        iaddr = 32'h40;
        dce   = 1'b1;
        daddr = 32'h104;
        step();
        idle_inputs();
        step();
        step();

        // Reset asserted while a fetch response is in flight.
        ice   = 1'b1;
        iaddr = 32'h08;
        step();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
        step();

        // Randomized traffic: a mixed phase, then a data-heavy phase.
        repeat (400) begin
            next_rand(50);
            step();
        end
        repeat (400) begin
            next_rand(95);
            step();
        end
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
